block_pool_2d: RTL and testbench

Parametrised 2D block pooling stage that reduces a raster-scan grayscale frame to a `OUT_W x OUT_H` grid of block statistics. It supports mean or max mode. Each output is computed over a true `BLK_W x BLK_H` rectangle, using one accumulator per output column. It sits between the camera/frame ingest and the spike-encoding front end, in the same position as the fixed-size pooler it supersedes.

---
 rtl/block_pool_2d.sv | 205 ++++++++++++++++++++
 tb/tb_block_pool_2d.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_pool_2d.sv
// ============================================================================
// block_pool_2d
// ----------------------------------------------------------------------------
// Reduces a raster-scan grayscale frame to an OUT_W x OUT_H grid of block
// statistics (mean or max) over true BLK_W x BLK_H rectangles. One accumulator
// per output column is kept; a block row reuses the same accumulators.
//
// Ports
//   clk        : single clock
//   rst_n      : asynchronous active-low reset
//   pixel_in   : unsigned input pixel (DATA_W bits)
//   valid_in   : pixel qualifier, no backpressure
//   new_frame  : synchronous frame restart (clears position, latches mode)
//   mode       : 0 = mean, 1 = max; sampled only at frame start
//   pixel_out  : pooled block value, held between pulses
//   valid_out  : one-cycle pulse per pooled value
//   out_col    : block column index of pixel_out
//   out_row    : block row index of pixel_out
//   frame_done : one-cycle pulse after the last pixel of a frame
// ============================================================================
module block_pool_2d #(
    parameter  int IMG_W  = 1242,
    parameter  int IMG_H  = 375,
    parameter  int BLK_W  = 48,
    parameter  int BLK_H  = 47,
    parameter  int DATA_W = 8,
    localparam int OUT_W  = IMG_W / BLK_W,
    localparam int OUT_H  = IMG_H / BLK_H,
    localparam int ACC_W  = DATA_W + $clog2(BLK_W * BLK_H),
    localparam int OC_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int OR_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              valid_in,
    input  logic              new_frame,
    input  logic              mode,
    output logic [DATA_W-1:0] pixel_out,
    output logic              valid_out,
    output logic [OC_W-1:0]   out_col,
    output logic [OR_W-1:0]   out_row,
    output logic              frame_done
);

    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BXW  = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int BYW  = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int CW1  = CW + 1;
    localparam int RW1  = RW + 1;

    localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
    localparam logic [BXW-1:0]   BX_LAST  = BXW'(BLK_W - 1);
    localparam logic [BYW-1:0]   BY_LAST  = BYW'(BLK_H - 1);
    localparam logic [OC_W-1:0]  OX_LAST  = OC_W'(OUT_W - 1);
    localparam logic [OR_W-1:0]  OY_LAST  = OR_W'(OUT_H - 1);
    // One extra bit so the region bound fits even when it equals the frame size
    localparam logic [CW1-1:0]   REG_W_C  = CW1'(OUT_W * BLK_W);
    localparam logic [RW1-1:0]   REG_H_C  = RW1'(OUT_H * BLK_H);
    localparam logic [ACC_W-1:0] BLK_N    = ACC_W'(BLK_W * BLK_H);

    // Position of the next pixel and the latched mode
    logic [CW-1:0]   col_q, col_d, col_e;
    logic [RW-1:0]   row_q, row_d, row_e;
    logic [BXW-1:0]  bx_q,  bx_d,  bx_e;
    logic [BYW-1:0]  by_q,  by_d,  by_e;
    logic [OC_W-1:0] ox_q,  ox_d,  ox_e;
    logic [OR_W-1:0] oy_q,  oy_d,  oy_e;
    logic            mode_q, mode_d, mode_e;

    // Output registers
    logic [DATA_W-1:0] pixel_out_q;
    logic              valid_out_q;
    logic [OC_W-1:0]   out_col_q;
    logic [OR_W-1:0]   out_row_q;
    logic              frame_done_q;

    // Per-column accumulators; no reset needed since each block's first pixel loads
    logic [ACC_W-1:0] acc_q [OUT_W];

    logic              in_region;
    logic              blk_first;
    logic              acc_we;
    logic              blk_done;
    logic              frame_end;
    logic [ACC_W-1:0]  acc_cur;
    logic [ACC_W-1:0]  pix_ext;
    logic [ACC_W-1:0]  acc_new;
    logic [DATA_W-1:0] mean_val;
    logic [DATA_W-1:0] result;

    // new_frame makes the coincident pixel land at (0,0) under the new mode
    assign col_e  = new_frame ? '0 : col_q;
    assign row_e  = new_frame ? '0 : row_q;
    assign bx_e   = new_frame ? '0 : bx_q;
    assign by_e   = new_frame ? '0 : by_q;
    assign ox_e   = new_frame ? '0 : ox_q;
    assign oy_e   = new_frame ? '0 : oy_q;
    assign mode_e = new_frame ? mode : mode_q;

    // Counter advance. ox/oy saturate at the last block so the remainder
    // columns/rows cycle bx/by harmlessly; the region test gates accumulation.
    always_comb begin
        col_d  = col_e;
        row_d  = row_e;
        bx_d   = bx_e;
        by_d   = by_e;
        ox_d   = ox_e;
        oy_d   = oy_e;
        mode_d = mode_e;
        if (valid_in) begin
            if (col_e == COL_LAST) begin
                col_d = '0;
                bx_d  = '0;
                ox_d  = '0;
                if (row_e == ROW_LAST) begin
                    row_d  = '0;
                    by_d   = '0;
                    oy_d   = '0;
                    mode_d = mode;      // re-latch at the automatic frame wrap
                end else begin
                    row_d = row_e + 1'b1;
                    if (by_e == BY_LAST) begin
                        by_d = '0;
                        if (oy_e != OY_LAST) oy_d = oy_e + 1'b1;
                    end else begin
                        by_d = by_e + 1'b1;
                    end
                end
            end else begin
                col_d = col_e + 1'b1;
                if (bx_e == BX_LAST) begin
                    bx_d = '0;
                    if (ox_e != OX_LAST) ox_d = ox_e + 1'b1;
                end else begin
                    bx_d = bx_e + 1'b1;
                end
            end
        end
    end

    // Datapath: the completing pixel is folded in before the result is formed
    always_comb begin
        in_region = ({1'b0, col_e} < REG_W_C) && ({1'b0, row_e} < REG_H_C);
        blk_first = (bx_e == '0) && (by_e == '0);
        acc_cur   = acc_q[ox_e];
        pix_ext   = ACC_W'(pixel_in);
        if (blk_first)
            acc_new = pix_ext;
        else if (mode_e)
            acc_new = (pix_ext > acc_cur) ? pix_ext : acc_cur;
        else
            acc_new = acc_cur + pix_ext;
        mean_val  = DATA_W'(acc_new / BLK_N);
        result    = mode_e ? acc_new[DATA_W-1:0] : mean_val;
        acc_we    = valid_in && in_region;
        blk_done  = acc_we && (bx_e == BX_LAST) && (by_e == BY_LAST);
        frame_end = valid_in && (col_e == COL_LAST) && (row_e == ROW_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            mode_q       <= 1'b0;
            pixel_out_q  <= '0;
            valid_out_q  <= 1'b0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            mode_q       <= mode_d;
            valid_out_q  <= blk_done;
            frame_done_q <= frame_end;
            if (blk_done) begin
                pixel_out_q <= result;
                out_col_q   <= ox_e;
                out_row_q   <= oy_e;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc_we) acc_q[ox_e] <= acc_new;
    end

    assign pixel_out  = pixel_out_q;
    assign valid_out  = valid_out_q;
    assign out_col    = out_col_q;
    assign out_row    = out_row_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_block_pool_2d.sv
// Bench for block_pool_2d on a 10x7 frame with 4x3 blocks (2x2 outputs).
module tb_block_pool_2d;

    localparam int IMG_W  = 10;
    localparam int IMG_H  = 7;
    localparam int BLK_W  = 4;
    localparam int BLK_H  = 3;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] pixel_in;
    logic              valid_in;
    logic              new_frame;
    logic              mode;
    logic [DATA_W-1:0] pixel_out;
    logic              valid_out;
    logic [0:0]        out_col;
    logic [0:0]        out_row;
    logic              frame_done;

    always #5 clk = ~clk;

    block_pool_2d #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .BLK_W (BLK_W),
        .BLK_H (BLK_H),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .new_frame (new_frame),
        .mode      (mode),
        .pixel_out (pixel_out),
        .valid_out (valid_out),
        .out_col   (out_col),
        .out_row   (out_row),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [7:0] v;
        logic       oc;
        logic       orow;
    } exp_t;

    typedef struct {
        int         pat;
        bit         m;
        bit         gaps;
        logic [7:0] e0, e1, e2, e3;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[8];
    int         n_cmp, n_fail;
    int         t_col, t_row;
    bit         pend_valid, pend_done;
    logic [7:0] cur_exp[4];
    logic [9:0] last_out;

    function automatic logic [7:0] pat_fn(input int pat, input int r, input int c);
        case (pat)
            0:       return 8'd200;
            1:       return 8'(c + 10 * r);
            2:       return (r == 4 && c == 6) ? 8'd255 :
                            (((r == 4 && c == 8) || (r == 6 && c == 0)) ? 8'd254 : 8'd0);
            3:       return (((r + c) % 2) == 1) ? 8'd255 : 8'd0;
            default: return 8'd255;
        endcase
    endfunction

    task automatic set_exp(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        cur_exp[0] = a; cur_exp[1] = b; cur_exp[2] = c; cur_exp[3] = d;
    endtask

    // Compares the outputs produced by the previous active edge
    task automatic check_outputs();
        exp_t       e;
        logic [9:0] act;
        act = {pixel_out, out_col, out_row};
        n_cmp++;
        if (valid_out !== pend_valid) begin
            n_fail++;
            $display("FAIL valid_out: got %b want %b at %0t", valid_out, pend_valid, $time);
        end
        n_cmp++;
        if (pend_valid) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                last_out = {e.v, e.oc, e.orow};
                if (act !== last_out) begin
                    n_fail++;
                    $display("FAIL result: got val=%0d col=%0d row=%0d want val=%0d col=%0d row=%0d",
                             pixel_out, out_col, out_row, e.v, e.oc, e.orow);
                end else begin
                    $display("out (%0d,%0d) = %0d", out_row, out_col, pixel_out);
                end
            end
        end else if (act !== last_out) begin
            n_fail++;
            $display("FAIL hold: got %h want %h at %0t", act, last_out, $time);
        end
        n_cmp++;
        if (frame_done !== pend_done) begin
            n_fail++;
            $display("FAIL frame_done: got %b want %b at %0t", frame_done, pend_done, $time);
        end else if (pend_done) begin
            $display("frame_done at %0t", $time);
        end
    endtask

    // One cycle: check previous results, then drive and predict this one
    task automatic step(input bit v, input logic [7:0] p, input bit nf, input bit m);
        int idx;
        @(negedge clk);
        check_outputs();
        valid_in   = v;
        pixel_in   = p;
        new_frame  = nf;
        mode       = m;
        pend_valid = 1'b0;
        pend_done  = 1'b0;
        if (nf) begin
            t_col = 0;
            t_row = 0;
        end
        if (v) begin
            if (t_col < 8 && t_row < 6 && (t_col % 4) == 3 && (t_row % 3) == 2) begin
                idx = (t_row / 3) * 2 + (t_col / 4);
                exp_q.push_back('{v: cur_exp[idx], oc: 1'(t_col / 4), orow: 1'(t_row / 3)});
                pend_valid = 1'b1;
            end
            if (t_col == IMG_W - 1 && t_row == IMG_H - 1) pend_done = 1'b1;
            if (t_col == IMG_W - 1) begin
                t_col = 0;
                t_row = (t_row == IMG_H - 1) ? 0 : t_row + 1;
            end else begin
                t_col = t_col + 1;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 8'($urandom), 1'b0, 1'($urandom));
    endtask

    task automatic drive_pix(input int pat, input bit nf, input bit m);
        int r, c;
        r = nf ? 0 : t_row;
        c = nf ? 0 : t_col;
        step(1'b1, pat_fn(pat, r, c), nf, m);
    endtask

    // Mode is toggled randomly while pixels stream; it must not take effect
    task automatic run_pixels(input int pat, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) idle();
            drive_pix(pat, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 1'b0, 8'd200, 8'd200, 8'd200, 8'd200};
        vecs[1] = '{1, 1'b0, 1'b0, 8'd11,  8'd15,  8'd41,  8'd45};
        vecs[2] = '{2, 1'b1, 1'b0, 8'd0,   8'd0,   8'd0,   8'd255};
        vecs[3] = '{1, 1'b1, 1'b0, 8'd23,  8'd27,  8'd53,  8'd57};
        vecs[4] = '{3, 1'b0, 1'b0, 8'd127, 8'd127, 8'd127, 8'd127};
        vecs[5] = '{4, 1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255};
        vecs[6] = '{1, 1'b0, 1'b1, 8'd11,  8'd15,  8'd41,  8'd45};
        vecs[7] = '{0, 1'b1, 1'b1, 8'd200, 8'd200, 8'd200, 8'd200};

        n_cmp = 0; n_fail = 0; t_col = 0; t_row = 0;
        pend_valid = 1'b0; pend_done = 1'b0; last_out = '0;
        rst_n = 1'b0; valid_in = 1'b0; pixel_in = '0; new_frame = 1'b0; mode = 1'b0;
        set_exp(8'd0, 8'd0, 8'd0, 8'd0);

        repeat (3) @(negedge clk);
        n_cmp++;
        if ({pixel_out, out_col, out_row, valid_out, frame_done} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0",
                     {pixel_out, out_col, out_row, valid_out, frame_done});
        end
        rst_n = 1'b1;

        // Table-driven full frames
        for (int k = 0; k < 8; k++) begin
            $display("frame %0d: pat=%0d mode=%0d gaps=%0d", k, vecs[k].pat, vecs[k].m, vecs[k].gaps);
            set_exp(vecs[k].e0, vecs[k].e1, vecs[k].e2, vecs[k].e3);
            step(1'b0, 8'd0, 1'b1, vecs[k].m);
            run_pixels(vecs[k].pat, IMG_W * IMG_H, vecs[k].gaps);
        end

        // new_frame with a coincident pixel at pixel 30, mode flipped to max
        $display("seq: new_frame abort");
        set_exp(8'd11, 8'd15, 8'd41, 8'd45);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        run_pixels(1, 30, 1'b0);
        set_exp(8'd23, 8'd27, 8'd53, 8'd57);
        drive_pix(1, 1'b1, 1'b1);
        run_pixels(1, IMG_W * IMG_H - 1, 1'b0);

        // Automatic wrap re-latches mode from the frame's last pixel
        $display("seq: wrap relatch");
        set_exp(8'd11, 8'd15, 8'd41, 8'd45);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        run_pixels(1, IMG_W * IMG_H - 1, 1'b0);
        drive_pix(1, 1'b0, 1'b1);
        set_exp(8'd23, 8'd27, 8'd53, 8'd57);
        run_pixels(1, IMG_W * IMG_H, 1'b0);

        // Asynchronous reset in the middle of block row 1
        $display("seq: async reset");
        set_exp(8'd11, 8'd15, 8'd41, 8'd45);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        run_pixels(1, 36, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pixel_out, out_col, out_row, valid_out, frame_done} !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h want 0",
                     {pixel_out, out_col, out_row, valid_out, frame_done});
        end
        valid_in = 1'b0; new_frame = 1'b0; mode = 1'b0;
        pend_valid = 1'b0; pend_done = 1'b0; last_out = '0;
        t_col = 0; t_row = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_pixels(1, IMG_W * IMG_H, 1'b0);

        idle();
        idle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
